// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, control bit indices and payload layout for pipeline stages
package pipe_pkg;

    localparam int MEMWB_CTRL_W = 4;
    localparam int MEMWB_DATA_W = 52;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_PCS      = 2;
    localparam int CTRL_HALT     = 3;

    localparam int ALU_HI   = 51;
    localparam int ALU_LO   = 36;
    localparam int MEM_HI   = 35;
    localparam int MEM_LO   = 20;
    localparam int PCINC_HI = 19;
    localparam int PCINC_LO = 4;
    localparam int RD_HI    = 3;
    localparam int RD_LO    = 0;

    function automatic logic [MEMWB_DATA_W-1:0] memwb_pack(
        input logic [15:0] alu,
        input logic [15:0] mem,
        input logic [15:0] pcinc,
        input logic [3:0]  rd
    );
        return {alu, mem, pcinc, rd};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid bit plus ctrl/data register; clear wins over load
module pipe_slot #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 52
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              v,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic              v_q, v_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clear only drops the valid bit; payload registers keep their contents.
    always_comb begin
        v_d    = v_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clear) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d    = 1'b1;
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign v      = v_q;
    assign q_ctrl = ctrl_q;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
// Optional PIPE_STAGE_PERF_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int DATA_W = MEMWB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    logic              m_v, s_v;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;

    logic              acc, pop;
    logic              m_load, m_clear, s_load, s_clear;
    logic [CTRL_W-1:0] m_src_ctrl;
    logic [DATA_W-1:0] m_src_data;

    assign in_ready = !s_v;
    assign acc      = in_valid & in_ready;
    assign pop      = m_v & out_ready;

    // acc can never coincide with a full skid, so the skid source only matters on pop.
    always_comb begin
        m_load     = (!m_v & acc) | (pop & (s_v | acc));
        m_clear    = flush | (pop & !s_v & !acc);
        s_load     = m_v & !pop & acc;
        s_clear    = flush | (pop & s_v);
        m_src_ctrl = s_v ? s_ctrl : in_ctrl;
        m_src_data = s_v ? s_data : in_data;
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (m_load),
        .clear  (m_clear),
        .d_ctrl (m_src_ctrl),
        .d_data (m_src_data),
        .v      (m_v),
        .q_ctrl (m_ctrl),
        .q_data (m_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (s_load),
        .clear  (s_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .v      (s_v),
        .q_ctrl (s_ctrl),
        .q_data (s_data)
    );

    assign out_valid = m_v;
    assign out_ctrl  = m_v ? m_ctrl : '0;
    assign out_data  = m_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Counters survive flush on purpose; only rst clears them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (m_v && !out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (!m_v && bubble_cnt_q != 16'hFFFF)
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - table-driven directed checks for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int CW = 4;
    localparam int DW = 52;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [DW-1:0] e_od;
        logic          e_ir;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [CW-1:0] oc,
                           input logic [DW-1:0] od, input logic ir);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".out_ctrl"},  64'(out_ctrl),  64'(oc));
        chk({tag, ".out_data"},  64'(out_data),  64'(od));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(ir));
    endtask

    function automatic vec_t mk(logic iv, logic [CW-1:0] ic, logic [DW-1:0] id, logic ordy,
                                logic fl, logic e_ov, logic [CW-1:0] e_oc,
                                logic [DW-1:0] e_od, logic e_ir);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl;
    endtask

    initial begin
        // streaming at full rate, 1-cycle latency
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 4'b0011, DW'(k), 1, 0, 1, 4'b0011, DW'(k), 1));
        // drain: bubble keeps last payload, ctrl forced low
        vecs.push_back(mk(0, 4'b0000, '0, 1, 0, 0, 4'b0000, 52'h8, 1));
        // backpressure: A, B accepted, C held upstream
        vecs.push_back(mk(1, 4'b0001, 52'hA, 0, 0, 1, 4'b0001, 52'hA, 1));
        vecs.push_back(mk(1, 4'b0010, 52'hB, 0, 0, 1, 4'b0001, 52'hA, 0));
        vecs.push_back(mk(1, 4'b0100, 52'hC, 0, 0, 1, 4'b0001, 52'hA, 0));
        vecs.push_back(mk(1, 4'b0100, 52'hC, 1, 0, 1, 4'b0010, 52'hB, 1));
        vecs.push_back(mk(1, 4'b0100, 52'hC, 1, 0, 1, 4'b0100, 52'hC, 1));
        vecs.push_back(mk(0, 4'b0000, '0,    1, 0, 0, 4'b0000, 52'hC, 1));
        // flush with two held entries and a concurrent offer of F
        vecs.push_back(mk(1, 4'b0101, 52'hD, 0, 0, 1, 4'b0101, 52'hD, 1));
        vecs.push_back(mk(1, 4'b0110, 52'hE, 0, 0, 1, 4'b0101, 52'hD, 0));
        vecs.push_back(mk(1, 4'b0111, 52'hF, 0, 1, 0, 4'b0000, 52'hD, 1));
        vecs.push_back(mk(0, 4'b0000, '0,    1, 0, 0, 4'b0000, 52'hD, 1));
        // flush while empty also drops the offered entry
        vecs.push_back(mk(1, 4'b0111, 52'hF, 1, 1, 0, 4'b0000, 52'hD, 1));
        vecs.push_back(mk(1, 4'b1000, 52'h9, 0, 0, 1, 4'b1000, 52'h9, 1));
        vecs.push_back(mk(0, 4'b0000, '0,    0, 0, 1, 4'b1000, 52'h9, 1));
        vecs.push_back(mk(0, 4'b0000, '0,    1, 0, 0, 4'b0000, 52'h9, 1));

        #2;
        chk_out("reset", 0, '0, '0, 1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_oc, vecs[i].e_od, vecs[i].e_ir);
            @(negedge clk);
        end

        // async reset mid-stream with two entries held
        drive(1, 4'b1001, 52'h11, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 4'b1010, 52'h22, 0, 0);
        @(posedge clk); #1;
        chk_out("full", 1, 4'b1001, 52'h11, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, '0, '0, 1);
        @(negedge clk);
        drive(0, '0, '0, 1, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_out("post_rst", 0, '0, '0, 1);

`ifdef PIPE_STAGE_PERF_EN
        begin
            logic [15:0] b0;
            @(negedge clk);
            rst = 1'b1; #1; rst = 1'b0;
            drive(1, 4'b0001, 52'h5, 0, 0);
            @(posedge clk); #1;
            b0 = bubble_cnt;
            @(negedge clk);
            drive(0, '0, '0, 0, 0);
            repeat (3) @(posedge clk);
            #1;
            chk("stall3", 64'(stall_cnt), 64'd3);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            repeat (2) @(posedge clk);
            #1;
            chk("bubble2", 64'(bubble_cnt - b0), 64'd2);
            chk("stall_hold", 64'(stall_cnt), 64'd3);
            repeat (70000) @(posedge clk);
            #1;
            chk("bubble_sat", 64'(bubble_cnt), 64'hFFFF);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed-width stall-only stage latches (IF/ID, ID/EX, EX/M, M/WB).
- Carries a control field and a data payload with valid/ready flow control, a 2-entry skid buffer and synchronous flush.
- Lets the cache-miss stall propagate one stage per cycle instead of broadcasting a global write-enable.
- Instantiated once per pipeline boundary. M/WB uses CTRL_W=4 and DATA_W=52.

Parameters:
CTRL_W, 4, control bits; forced to zero whenever the slot is invalid (bubble)
DATA_W, 52, payload bits (M/WB default: ALU result 16 + memory data 16 + PC+2 16 + Rd 4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept this cycle
in_ctrl  in  CTRL_W  upstream control bits
in_data  in  DATA_W  upstream payload
out_valid  out  1  entry presented downstream
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control bits; all zero when out_valid=0
out_data  out  DATA_W  payload; holds last value when out_valid=0

Behaviour:
- State: main slot (m_v, m_ctrl, m_data) drives outputs; skid slot (s_v, s_ctrl, s_data).
- in_ready = !s_v. It is a pure flop output, with no combinational path from out_ready.
- acc = in_valid & in_ready. pop = out_valid & out_ready.
- out_valid = m_v. out_ctrl = m_v ? m_ctrl : 0. out_data = m_data.
- Reset (async, rst=1): m_v=0, s_v=0, all ctrl/data regs 0. Therefore out_valid=0, out_ctrl=0, out_data=0, in_ready=1. Release takes effect at the next edge; no partial entries survive a mid-operation reset.
- Next-state rules per edge; flush has priority over everything:
  - flush=1: m_v<=0, s_v<=0. An entry offered in the same cycle is dropped even though in_ready was 1. Data regs unchanged.
  - !m_v & acc: main<=in. Latency in->out is 1 cycle.
  - m_v & pop & s_v: main<=skid, s_v<=0. An incoming entry cannot arrive here because in_ready=0.
  - m_v & pop & !s_v & acc: main<=in. Gives full throughput, 1 entry/cycle.
  - m_v & pop & !s_v & !acc: m_v<=0.
  - m_v & !pop & acc: skid<=in, s_v<=1. Buffer is now full; in_ready=0 next cycle.
  - m_v & !pop & !acc: hold.
- Ordering is strictly FIFO. Max occupancy is 2. No entry is ever duplicated or lost except by flush/reset.
- out_valid, once asserted, remains asserted with stable ctrl/data until pop or flush.
- Data registers load only on the cases above, so there is no toggling on hold.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: adds outputs stall_cnt[15:0] and bubble_cnt[15:0], reset to 0 and cleared by rst only.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at 16'hFFFF and are not cleared by flush.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - M/WB widths: MEMWB_CTRL_W=4, MEMWB_DATA_W=52.
  - Ctrl bit indices: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_PCS=2, CTRL_HALT=3.
  - Payload field offsets: ALU 51:36, MEM 35:20, PCINC 19:4, RD 3:0.
- Sub-module pipe_slot: one valid bit plus ctrl/data register with load, clear and async reset. Instantiated twice (main, skid).

Test Plan:
- Reset: assert rst mid-stream with 2 entries held -> immediately out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, push ctrl=4'b0011, data=52'h1 to 52'h8 on consecutive cycles -> same sequence out, 1-cycle latency, in_ready constantly 1.
- Backpressure: hold out_ready=0 and push A=52'hA, B=52'hB, C=52'hC.
  - A and B are accepted; in_ready=0 the cycle after B; C is held upstream.
  - Release out_ready -> A, B, C emerge in order, no loss.
- Flush: with 2 entries held, flush=1 and in_valid=1 with 52'hF -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 52'hF never appears.
- Bubble control: in_valid=0 after draining -> out_ctrl=4'b0000 (RegWrite/HALT low) while out_data retains the last payload.
- PERF (macro defined): 3 stall cycles then 2 empty cycles -> stall_cnt=3, bubble_cnt=2. Force 70000 empty cycles -> bubble_cnt=16'hFFFF.
